// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
// Read-side valid/ready handshake of the receive FIFO.
//   rd_data  : head-of-FIFO byte, valid while rd_valid=1
//   rd_valid : FIFO holds at least one byte
//   rd_ready : consumer accepts the head byte at the clock edge
// Modports: master = FIFO (drives data/valid), slave = consumer (drives ready).
interface uart_rx_fifo_if;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;

    modport master (output rd_data, output rd_valid, input rd_ready);
    modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Circular byte FIFO behind the UART receiver. One byte is written per rising
// edge of rx_done; bytes are presented first-word-fall-through on rd_if.
// Ports:
//   clk, rst          : system clock, asynchronous active-high reset
//   data_out, rx_done : byte and completion strobe/level from uart_rx1
//   rd_if (master)    : rd_data / rd_valid / rd_ready read handshake
//   count, full, empty: fill level and its decodes
//   overrun           : sticky, a byte was dropped while full
//   overrun_clr       : synchronous clear of overrun (a new overrun wins)
//   wm_hit            : only with UART_RX_FIFO_WATERMARK_EN, count >= WATERMARK
// Optional feature macro: UART_RX_FIFO_WATERMARK_EN.
module uart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int WATERMARK = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             data_out,
    input  logic                   rx_done,
    uart_rx_fifo_if.master         rd_if,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overrun,
    input  logic                   overrun_clr
`ifdef UART_RX_FIFO_WATERMARK_EN
    ,
    output logic                   wm_hit
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
    end
    if ((WATERMARK < 1) || (WATERMARK > DEPTH)) begin : g_bad_wm
        $error("uart_rx_fifo: WATERMARK must be in 1..DEPTH");
    end

    logic [7:0]    mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          rx_done_q, rx_done_d;

    logic          wr_stb;
    logic          pop;
    logic          wr_acc;
    logic          drop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    assign wr_stb = rx_done & ~rx_done_q;
    assign pop    = ~empty & rd_if.rd_ready;
    // A pop at the same edge frees the slot the write needs.
    assign wr_acc = wr_stb & (~full | pop);
    assign drop   = wr_stb & full & ~pop;

    always_comb begin
        rx_done_d = rx_done;
        wr_ptr_d  = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        if (wr_acc && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !wr_acc) begin
            count_d = count_q - CW'(1);
        end

        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    // rx_done_q resets high so a level already asserted at release is not a new byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_done_q <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            rx_done_q <= rx_done_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= data_out;
        end
    end

    assign rd_if.rd_data  = mem[rd_ptr_q];
    assign rd_if.rd_valid = ~empty;
    assign count          = count_q;
    assign overrun        = overrun_q;

`ifdef UART_RX_FIFO_WATERMARK_EN
    logic wm_hit_q, wm_hit_d;

    assign wm_hit_d = (count_d >= CW'(WATERMARK));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wm_hit_q <= 1'b0;
        end else begin
            wm_hit_q <= wm_hit_d;
        end
    end

    assign wm_hit = wm_hit_q;
`endif

endmodule
